// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream and writes little-endian 32-bit words into
// instruction or data memory, holding the CPU in reset until the frame checksum verifies.
module program_loader #(
    parameter logic [7:0] MAGIC          = 8'hA5,
    parameter int         IMEM_WORDS     = 8192,
    parameter int         DMEM_WORDS     = 131072,
    parameter int         TIMEOUT_CYCLES = 2097151
) (
    input  logic        clk,
    input  logic        reset_low,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [12:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        dmem_we,
    output logic [16:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TARGET, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_CHECK, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            tgt_q, tgt_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     word_q, word_d;
    logic [16:0]     waddr_q, waddr_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [7:0]      chk_q, chk_d;
    logic [TO_W-1:0] idle_q, idle_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic        accept;
    logic [15:0] cnt_in;
    logic [31:0] depth_sel;
    logic        too_big;
    logic        last_word;
    logic        timeout_hit;

    assign accept      = in_valid & in_ready;
    assign cnt_in      = {in_data, cnt_q[7:0]};
    assign depth_sel   = tgt_q ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);
    assign too_big     = {16'd0, cnt_in} > depth_sel;
    assign last_word   = (waddr_q + 17'd1) == {1'b0, cnt_q};
    assign timeout_hit = idle_q >= TO_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && in_data == MAGIC) state_d = S_TARGET;
            S_TARGET: if (accept) state_d = (in_data[7:1] == 7'd0) ? S_CNT_LO : S_ERR;
            S_CNT_LO: if (accept) state_d = S_CNT_HI;
            S_CNT_HI: if (accept) state_d = too_big ? S_ERR : (cnt_in == 16'd0) ? S_CHECK : S_DATA;
            S_DATA:   if (accept && bidx_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? S_CHECK : S_DATA;
            S_CHECK:  if (accept) state_d = (in_data == chk_q) ? S_IDLE : S_ERR;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A silent source aborts any in-progress frame; WRITE never waits on input.
        if (!accept && timeout_hit &&
            state_q inside {S_TARGET, S_CNT_LO, S_CNT_HI, S_DATA, S_CHECK})
            state_d = S_ERR;
    end

    always_comb begin
        in_ready = (state_q != S_WRITE);
        imem_we  = (state_q == S_WRITE) && !tgt_q;
        dmem_we  = (state_q == S_WRITE) &&  tgt_q;
    end

    assign imem_addr  = waddr_q[12:0];
    assign dmem_addr  = waddr_q;
    assign imem_wdata = word_q;
    assign dmem_wdata = word_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

    always_comb begin
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        waddr_d = waddr_q;
        bidx_d  = bidx_q;
        chk_d   = chk_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (accept || state_q inside {S_IDLE, S_ERR, S_WRITE}) idle_d = '0;
        else if (idle_q != {TO_W{1'b1}})                       idle_d = idle_q + 1'b1;
        else                                                   idle_d = idle_q;
        case (state_q)
            S_IDLE: if (accept && in_data == MAGIC) begin
                hold_d  = 1'b1;
                err_d   = 1'b0;
                chk_d   = 8'd0;
                waddr_d = 17'd0;
                bidx_d  = 2'd0;
            end
            S_TARGET: if (accept) begin
                tgt_d = in_data[0];
                chk_d = chk_q ^ in_data;
            end
            S_CNT_LO: if (accept) begin
                cnt_d[7:0] = in_data;
                chk_d      = chk_q ^ in_data;
            end
            S_CNT_HI: if (accept) begin
                cnt_d[15:8] = in_data;
                chk_d       = chk_q ^ in_data;
            end
            S_DATA: if (accept) begin
                word_d = {in_data, word_q[31:8]};
                bidx_d = bidx_q + 2'd1;
                chk_d  = chk_q ^ in_data;
            end
            S_WRITE: waddr_d = waddr_q + 17'd1;
            S_CHECK: if (accept && in_data == chk_q) begin
                done_d = 1'b1;
                hold_d = 1'b0;
            end
            default: ;
        endcase
        if (state_d == S_ERR) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            tgt_q   <= 1'b0;
            cnt_q   <= 16'd0;
            word_q  <= 32'd0;
            waddr_q <= 17'd0;
            bidx_q  <= 2'd0;
            chk_q   <= 8'd0;
            idle_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            waddr_q <= waddr_d;
            bidx_q  <= bidx_d;
            chk_q   <= chk_d;
            idle_q  <= idle_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan plus
// randomized frames compared against a frame-parsing reference model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset_low;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [12:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [16:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    program_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset_low  (reset_low),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // write record: {memory select (1=dmem), word address, data}
    logic [49:0] got_q[$];
    logic [49:0] exp_q[$];
    int          done_cnt;
    int          exp_done;
    logic        exp_err;
    logic        exp_hold;
    int          wait_q[$];
    logic [7:0]  frm[$];

    always @(negedge clk) begin
        if (reset_low) begin
            if (imem_we)   got_q.push_back({1'b0, 4'd0, imem_addr, imem_wdata});
            if (dmem_we)   got_q.push_back({1'b1, dmem_addr, dmem_wdata});
            if (load_done) done_cnt++;
        end
    end

    // Reference: parse the byte list as the frame format defines it.
    task automatic model(input logic [7:0] b[$]);
        int i;
        int cnt;
        int depth;
        int k;
        logic [7:0] c;
        logic [31:0] d;
        exp_q.delete();
        exp_done = 0;
        i = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i >= b.size()) return;
        exp_err  = 1'b0;
        exp_hold = 1'b1;
        if (b[i+1] > 8'd1) begin exp_err = 1'b1; return; end
        c     = b[i+1] ^ b[i+2] ^ b[i+3];
        cnt   = int'(b[i+3]) * 256 + int'(b[i+2]);
        depth = (b[i+1] == 8'd1) ? 131072 : 8192;
        if (cnt > depth) begin exp_err = 1'b1; return; end
        for (int w = 0; w < cnt; w++) begin
            k = i + 4 + 4 * w;
            d = {b[k+3], b[k+2], b[k+1], b[k]};
            c = c ^ b[k] ^ b[k+1] ^ b[k+2] ^ b[k+3];
            exp_q.push_back({b[i+1][0], 17'(w), d});
        end
        if (b[i + 4 + 4 * cnt] == c) begin exp_done = 1; exp_hold = 1'b0; end
        else exp_err = 1'b1;
    endtask

    task automatic build_frame(input logic [7:0] tgt, input int cnt, input bit corrupt);
        logic [7:0] c;
        logic [31:0] w;
        frm.delete();
        frm.push_back(8'hA5);
        frm.push_back(tgt);
        frm.push_back(8'(cnt));
        frm.push_back(8'(cnt >> 8));
        c = tgt ^ 8'(cnt) ^ 8'(cnt >> 8);
        for (int n = 0; n < cnt; n++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                frm.push_back(w[8*j +: 8]);
                c = c ^ w[8*j +: 8];
            end
        end
        frm.push_back(corrupt ? ~c : c);
    endtask

    // Called and returns on a falling edge; records how many cycles in_ready was low.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 8) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            bad++;
            total++;
            $display("FAIL ready_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
        @(negedge clk);
        wait_q.push_back(waited);
    endtask

    task automatic drive_frame(input logic [7:0] b[$], input int maxgap, input int tail);
        int gap;
        wait_q.delete();
        foreach (b[n]) begin
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send_byte(b[n]);
        end
        in_valid = 1'b0;
        repeat (tail) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [99:0] obs;
        obs = {in_ready, imem_we, dmem_we, cpu_hold, load_done, load_err,
               imem_addr, dmem_addr, imem_wdata, dmem_wdata};
        total++;
        if (obs !== {6'b100000, 94'd0}) begin
            bad++;
            $display("FAIL reset_values got=%h required=%h", obs, {6'b100000, 94'd0});
        end
    endtask

    task automatic test_imem_two_words;
        frm = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        got_q.delete();
        done_cnt = 0;
        model(frm);
        drive_frame(frm, 0, 3);
        total++;
        if (got_q.size() != 2) begin
            bad++;
            $display("FAIL imem2_nwrites got=%0d required=2", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== {1'b0, 17'd0, 32'h12345678}) begin
                bad++;
                $display("FAIL imem2_w0 got=%h required=%h", got_q[0], {1'b0, 17'd0, 32'h12345678});
            end
            total++;
            if (got_q[1] !== {1'b0, 17'd1, 32'hDEADBEEF}) begin
                bad++;
                $display("FAIL imem2_w1 got=%h required=%h", got_q[1], {1'b0, 17'd1, 32'hDEADBEEF});
            end
        end
        total++;
        if (done_cnt != 1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL imem2_status done=%0d hold=%b err=%b required done=1 hold=0 err=0",
                     done_cnt, cpu_hold, load_err);
        end
    endtask

    task automatic test_bad_checksum;
        frm = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
        got_q.delete();
        done_cnt = 0;
        model(frm);
        drive_frame(frm, 1, 3);
        total++;
        if (got_q != exp_q) begin
            bad++;
            $display("FAIL badchk_writes got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        total++;
        if (done_cnt != exp_done || load_err !== exp_err || cpu_hold !== exp_hold) begin
            bad++;
            $display("FAIL badchk_status done=%0d err=%b hold=%b required done=%0d err=%b hold=%b",
                     done_cnt, load_err, cpu_hold, exp_done, exp_err, exp_hold);
        end
        build_frame(8'h01, 2, 1'b0);
        got_q.delete();
        done_cnt = 0;
        model(frm);
        drive_frame(frm, 0, 3);
        total++;
        if (got_q != exp_q || done_cnt != 1 || load_err !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL recover_after_err writes=%0d done=%0d err=%b hold=%b required writes=%0d done=1 err=0 hold=0",
                     got_q.size(), done_cnt, load_err, cpu_hold, exp_q.size());
        end
    endtask

    task automatic test_header_errors;
        frm = '{8'hA5, 8'h02};
        got_q.delete();
        done_cnt = 0;
        drive_frame(frm, 0, 1);
        total++;
        if (load_err !== 1'b1 || cpu_hold !== 1'b1 || got_q.size() != 0) begin
            bad++;
            $display("FAIL bad_target err=%b hold=%b writes=%0d required err=1 hold=1 writes=0",
                     load_err, cpu_hold, got_q.size());
        end
        frm = '{8'hA5, 8'h00, 8'h01, 8'h20};
        got_q.delete();
        model(frm);
        drive_frame(frm, 0, 2);
        total++;
        if (load_err !== exp_err || cpu_hold !== exp_hold || got_q.size() != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL cnt_overflow err=%b hold=%b writes=%0d done=%0d required err=%b hold=%b writes=0 done=0",
                     load_err, cpu_hold, got_q.size(), done_cnt, exp_err, exp_hold);
        end
    endtask

    task automatic test_zero_count;
        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01};
        got_q.delete();
        done_cnt = 0;
        drive_frame(frm, 0, 3);
        total++;
        if (got_q.size() != 0 || done_cnt != 1 || cpu_hold !== 1'b0 || load_err !== 1'b0) begin
            bad++;
            $display("FAIL zero_count writes=%0d done=%0d hold=%b err=%b required writes=0 done=1 hold=0 err=0",
                     got_q.size(), done_cnt, cpu_hold, load_err);
        end
    endtask

    task automatic test_timeout;
        frm = '{8'h00, 8'h11, 8'hA5, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
        got_q.delete();
        done_cnt = 0;
        drive_frame(frm, 0, 0);
        repeat (15) @(negedge clk);
        total++;
        if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early err=%b hold=%b required err=0 hold=1", load_err, cpu_hold);
        end
        @(negedge clk);
        total++;
        if (load_err !== 1'b1 || cpu_hold !== 1'b1 || got_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_fire err=%b hold=%b writes=%0d required err=1 hold=1 writes=0",
                     load_err, cpu_hold, got_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        frm = '{8'hA5, 8'h00, 8'h03, 8'h00,
                8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hC3, 8'h5A, 8'h00, 8'hFF, 8'h00};
        frm[16] = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5] ^ frm[6] ^ frm[7] ^ frm[8]
                ^ frm[9] ^ frm[10] ^ frm[11] ^ frm[12] ^ frm[13] ^ frm[14] ^ frm[15];
        got_q.delete();
        done_cnt = 0;
        model(frm);
        drive_frame(frm, 0, 3);
        foreach (wait_q[j]) begin
            total++;
            if (wait_q[j] != ((j == 8 || j == 12 || j == 16) ? 1 : 0)) begin
                bad++;
                $display("FAIL b2b_ready byte=%0d stall=%0d required=%0d", j, wait_q[j],
                         (j == 8 || j == 12 || j == 16) ? 1 : 0);
            end
        end
        total++;
        if (got_q != exp_q || done_cnt != 1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL b2b_writes writes=%0d done=%0d hold=%b required writes=3 done=1 hold=0",
                     got_q.size(), done_cnt, cpu_hold);
        end
    endtask

    task automatic test_midframe_reset;
        logic [99:0] obs;
        frm = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        drive_frame(frm, 0, 0);
        total++;
        if (cpu_hold !== 1'b1 || imem_wdata === 32'd0) begin
            bad++;
            $display("FAIL pre_reset hold=%b wdata=%h required hold=1 wdata!=0", cpu_hold, imem_wdata);
        end
        #2 reset_low = 1'b0;
        #1;
        obs = {in_ready, imem_we, dmem_we, cpu_hold, load_done, load_err,
               imem_addr, dmem_addr, imem_wdata, dmem_wdata};
        total++;
        if (obs !== {6'b100000, 94'd0}) begin
            bad++;
            $display("FAIL async_reset got=%h required=%h", obs, {6'b100000, 94'd0});
        end
        @(negedge clk);
        reset_low = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random_frames;
        for (int n = 0; n < 8; n++) begin
            build_frame(8'($urandom_range(0, 1)), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
            got_q.delete();
            done_cnt = 0;
            model(frm);
            drive_frame(frm, 2, 3);
            total++;
            if (got_q != exp_q) begin
                bad++;
                $display("FAIL rand%0d_writes got=%0d required=%0d", n, got_q.size(), exp_q.size());
            end
            total++;
            if (done_cnt != exp_done || load_err !== exp_err || cpu_hold !== exp_hold) begin
                bad++;
                $display("FAIL rand%0d_status done=%0d err=%b hold=%b required done=%0d err=%b hold=%b",
                         n, done_cnt, load_err, cpu_hold, exp_done, exp_err, exp_hold);
            end
        end
    endtask

    initial begin
        reset_low = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        done_cnt  = 0;
        repeat (2) @(negedge clk);
        test_reset;
        reset_low = 1'b1;
        @(negedge clk);
        test_reset;
        test_imem_two_words;
        test_bad_checksum;
        test_header_errors;
        test_zero_count;
        test_timeout;
        test_back_to_back;
        test_midframe_reset;
        test_random_frames;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
